// File: rtl/dmem_io_arbiter_pkg.sv
// Shared constants and encodings for the data-memory / I/O arbiter.
// Holds the I/O region tag, register offsets, port ids and response sources.
package dmem_io_arbiter_pkg;

  localparam logic [3:0] IO_TAG = 4'hF;

  localparam logic [4:0] OFS_HEX  = 5'h00;
  localparam logic [4:0] OFS_LEDR = 5'h04;
  localparam logic [4:0] OFS_LEDG = 5'h08;
  localparam logic [4:0] OFS_KEY  = 5'h10;
  localparam logic [4:0] OFS_SW   = 5'h14;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_DBG = 1'b1
  } portId_t;

  typedef enum logic [2:0] {
    SRC_MEM  = 3'd0,
    SRC_HEX  = 3'd1,
    SRC_LEDR = 3'd2,
    SRC_LEDG = 3'd3,
    SRC_KEY  = 3'd4,
    SRC_SW   = 3'd5,
    SRC_NONE = 3'd6
  } respSrc_t;

  typedef struct packed {
    logic     valid;
    portId_t  port;
    respSrc_t src;
  } resp_t;

  // Decodes addr[4:2] of an I/O read into the register it returns.
  function automatic respSrc_t ioReadSrc(input logic [2:0] sel);
    if (sel[2]) begin
      return sel[0] ? SRC_SW : SRC_KEY;
    end
    if (sel[1:0] == OFS_HEX[3:2])  return SRC_HEX;
    if (sel[1:0] == OFS_LEDR[3:2]) return SRC_LEDR;
    if (sel[1:0] == OFS_LEDG[3:2]) return SRC_LEDG;
    return SRC_NONE;
  endfunction

endpackage

// File: rtl/dmem_io_arbiter_sync2.sv
// Two-flop synchronizer for asynchronous board inputs.
// Latency: 2 cycles; no backpressure.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dmem_io_arbiter.sv
// Arbitrates CPU and debug ports onto data memory plus memory-mapped board I/O.
// Latency: grant same cycle, read data 1 cycle later; losing port holds its request.
module dmem_io_arbiter #(
  parameter int         DATA_BIT_WIDTH = 32,
  parameter logic [3:0] IO_TAG         = dmem_io_arbiter_pkg::IO_TAG
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cpu_req,
  input  logic                      cpu_we,
  input  logic [DATA_BIT_WIDTH-1:0] cpu_addr,
  input  logic [DATA_BIT_WIDTH-1:0] cpu_wdata,
  output logic                      cpu_gnt,
  output logic                      cpu_rvalid,
  input  logic                      dbg_req,
  input  logic                      dbg_we,
  input  logic [DATA_BIT_WIDTH-1:0] dbg_addr,
  input  logic [DATA_BIT_WIDTH-1:0] dbg_wdata,
  output logic                      dbg_gnt,
  output logic                      dbg_rvalid,
  output logic [DATA_BIT_WIDTH-1:0] rdata,
  output logic                      mem_we,
  output logic [DATA_BIT_WIDTH-1:0] mem_addr,
  output logic [DATA_BIT_WIDTH-1:0] mem_wdata,
  input  logic [DATA_BIT_WIDTH-1:0] mem_rdata,
  output logic [31:0]               hex,
  output logic [17:0]               ledr,
  output logic [8:0]                ledg,
  input  logic [17:0]               sw,
  input  logic [3:0]                key
);

  import dmem_io_arbiter_pkg::*;

  typedef logic [DATA_BIT_WIDTH-1:0] word_t;

  portId_t     lastGrant;
  resp_t       resp;
  logic [17:0] swSync;
  logic [3:0]  keySync;

  logic  cpuWin;
  logic  dbgWin;
  logic  anyGnt;
  logic  winWe;
  word_t winAddr;
  word_t winWdata;
  logic  winIsIo;
  logic  memSel;
  logic  ioWrite;
  logic  respLive;

  sync2 #(.WIDTH(18)) uSwSync (
    .clk   (clk),
    .reset (reset),
    .d     (sw),
    .q     (swSync)
  );

  sync2 #(.WIDTH(4)) uKeySync (
    .clk   (clk),
    .reset (reset),
    .d     (key),
    .q     (keySync)
  );

  // Round-robin on contention: the port that did not win last time goes first.
  always_comb begin
    cpuWin = 1'b0;
    dbgWin = 1'b0;
    if (!reset) begin
      cpuWin = cpu_req && (!dbg_req || lastGrant == PORT_DBG);
      dbgWin = dbg_req && !cpuWin;
    end
  end

  assign anyGnt   = cpuWin || dbgWin;
  assign winWe    = dbgWin ? dbg_we    : cpu_we;
  assign winAddr  = dbgWin ? dbg_addr  : cpu_addr;
  assign winWdata = dbgWin ? dbg_wdata : cpu_wdata;
  assign winIsIo  = (winAddr[31:28] == IO_TAG);
  assign memSel   = anyGnt && !winIsIo;
  assign ioWrite  = anyGnt && winIsIo && winWe && !winAddr[4];

  assign cpu_gnt   = cpuWin;
  assign dbg_gnt   = dbgWin;
  assign mem_we    = memSel && winWe;
  assign mem_addr  = memSel ? winAddr  : '0;
  assign mem_wdata = memSel ? winWdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      lastGrant <= PORT_DBG;
      resp      <= '0;
      hex       <= '0;
      ledr      <= '0;
      ledg      <= '0;
    end else begin
      if (anyGnt) begin
        lastGrant <= dbgWin ? PORT_DBG : PORT_CPU;
      end
      resp.valid <= anyGnt && !winWe;
      resp.port  <= dbgWin ? PORT_DBG : PORT_CPU;
      resp.src   <= winIsIo ? ioReadSrc(winAddr[4:2]) : SRC_MEM;
      if (ioWrite) begin
        case (winAddr[3:2])
          OFS_HEX[3:2]:  hex  <= winWdata[31:0];
          OFS_LEDR[3:2]: ledr <= winWdata[17:0];
          OFS_LEDG[3:2]: ledg <= winWdata[8:0];
          default: ;
        endcase
      end
    end
  end

  // A response captured just before reset rises is suppressed here.
  assign respLive   = resp.valid && !reset;
  assign cpu_rvalid = respLive && (resp.port == PORT_CPU);
  assign dbg_rvalid = respLive && (resp.port == PORT_DBG);

  always_comb begin
    rdata = '0;
    if (respLive) begin
      case (resp.src)
        SRC_MEM:  rdata = mem_rdata;
        SRC_HEX:  rdata = word_t'(hex);
        SRC_LEDR: rdata = word_t'(ledr);
        SRC_LEDG: rdata = word_t'(ledg);
        SRC_KEY:  rdata = word_t'(keySync);
        SRC_SW:   rdata = word_t'(swSync);
        default:  rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_io_arbiter.sv
// Randomized and directed bench for dmem_io_arbiter against a transaction-level model.
// The model tracks pending requests per port, round-robin fairness and register contents.
module tb_dmem_io_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         cpu_req, cpu_we, dbg_req, dbg_we;
  logic [W-1:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic         cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
  logic [W-1:0] rdata, mem_addr, mem_wdata;
  logic [W-1:0] mem_rdata = '0;
  logic         mem_we;
  logic [31:0]  hex;
  logic [17:0]  ledr, sw;
  logic [8:0]   ledg;
  logic [3:0]   key;

  int testCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  dmem_io_arbiter #(.DATA_BIT_WIDTH(W), .IO_TAG(4'hF)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
    .rdata(rdata), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .hex(hex), .ledr(ledr), .ledg(ledg), .sw(sw), .key(key)
  );

  // Memory stub: synchronous read returning a fixed hash of the address.
  function automatic logic [31:0] memFn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  always @(posedge clk) mem_rdata <= memFn(mem_addr);

  // Reference model state
  logic        reqV [2];
  logic        reqWe[2];
  logic [31:0] reqA [2];
  logic [31:0] reqD [2];
  logic        mLast;
  logic [31:0] mHex;
  logic [17:0] mLedr, mSw;
  logic [8:0]  mLedg;
  logic [3:0]  mKey;
  logic        rspVld, rspPort;
  logic [31:0] rspAddr;
  logic [31:0] ioOfs [6] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14};

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] expRead(input logic [31:0] a);
    if (a[31:28] != 4'hF) return memFn(a);
    if (a[4]) return a[2] ? {14'b0, mSw} : {28'b0, mKey};
    case (a[3:2])
      2'b00:   return mHex;
      2'b01:   return {14'b0, mLedr};
      2'b10:   return {23'b0, mLedg};
      default: return 32'h0;
    endcase
  endfunction

  task automatic drive();
    cpu_req = reqV[0]; cpu_we = reqWe[0]; cpu_addr = reqA[0]; cpu_wdata = reqD[0];
    dbg_req = reqV[1]; dbg_we = reqWe[1]; dbg_addr = reqA[1]; dbg_wdata = reqD[1];
  endtask

  task automatic issue(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
    reqV[p] = 1'b1; reqWe[p] = we; reqA[p] = a; reqD[p] = d;
    drive();
  endtask

  task automatic genReq(input int p);
    logic [31:0] a;
    logic        we;
    we = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 2) == 0) begin
      a = 32'hF000_0000 | ioOfs[$urandom_range(0, 5)];
      if (!we && !a[4] && a[3:2] == 2'b11) we = 1'b1;
    end else begin
      a = $urandom;
      if (a[31:28] == 4'hF) a[31:28] = 4'h3;
    end
    issue(p, we, a, $urandom);
  endtask

  task automatic resetModel();
    mLast = 1'b1; mHex = '0; mLedr = '0; mLedg = '0; rspVld = 1'b0;
    for (int p = 0; p < 2; p++) begin
      reqV[p] = 1'b0; reqWe[p] = 1'b0; reqA[p] = '0; reqD[p] = '0;
    end
  endtask

  // One clock cycle: called with inputs applied just after a rising edge.
  task automatic stepCycle();
    logic        cWin, dWin, w, we;
    logic [31:0] a, d;
    cWin = reqV[0] && (!reqV[1] || mLast);
    dWin = reqV[1] && !cWin;
    @(negedge clk);
    checkEq("cpu_gnt", cpu_gnt, cWin);
    checkEq("dbg_gnt", dbg_gnt, dWin);
    checkEq("cpu_rvalid", cpu_rvalid, rspVld && !rspPort);
    checkEq("dbg_rvalid", dbg_rvalid, rspVld && rspPort);
    if (rspVld) checkEq("rdata", rdata, expRead(rspAddr));
    checkEq("hex", hex, mHex);
    checkEq("ledr", ledr, mLedr);
    checkEq("ledg", ledg, mLedg);
    rspVld = 1'b0;
    if (cWin || dWin) begin
      w = dWin; a = reqA[w]; d = reqD[w]; we = reqWe[w];
      if (a[31:28] != 4'hF) begin
        checkEq("mem_we", mem_we, we);
        checkEq("mem_addr", mem_addr, a);
        if (we) checkEq("mem_wdata", mem_wdata, d);
      end else begin
        checkEq("mem_we_io", mem_we, 1'b0);
        if (we && !a[4]) begin
          case (a[3:2])
            2'b00:   mHex  = d;
            2'b01:   mLedr = d[17:0];
            2'b10:   mLedg = d[8:0];
            default: ;
          endcase
        end
      end
      if (!we) begin
        rspVld = 1'b1; rspPort = w; rspAddr = a;
      end
      mLast = w;
      reqV[w] = 1'b0;
    end else begin
      checkEq("mem_we_idle", mem_we, 1'b0);
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  initial begin
    reset = 1'b1;
    sw = '0; key = '0; mSw = '0; mKey = '0;
    resetModel();
    issue(0, 1'b1, 32'h0000_0200, 32'h1111_1111);
    issue(1, 1'b1, 32'h0000_0300, 32'h2222_2222);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkEq("rst_cpu_gnt", cpu_gnt, 1'b0);
    checkEq("rst_dbg_gnt", dbg_gnt, 1'b0);
    checkEq("rst_mem_we", mem_we, 1'b0);
    checkEq("rst_rvalid", {cpu_rvalid, dbg_rvalid}, 2'b00);
    checkEq("rst_hex", hex, 32'h0);
    checkEq("rst_ledr", ledr, 18'h0);
    checkEq("rst_ledg", ledg, 9'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    resetModel();
    drive();

    // Contention on memory reads: CPU first, then alternating.
    for (int i = 0; i < 5; i++) begin
      if (!reqV[0]) issue(0, 1'b0, 32'h0000_1000 + 32'(i * 4), 32'h0);
      if (!reqV[1]) issue(1, 1'b0, 32'h0000_2000 + 32'(i * 4), 32'h0);
      stepCycle();
    end
    repeat (3) stepCycle();

    issue(0, 1'b1, 32'hF000_0000, 32'h1234_5678);
    stepCycle();
    stepCycle();
    issue(1, 1'b1, 32'hF000_0004, 32'hFFFF_FFFF);
    stepCycle();
    issue(0, 1'b1, 32'hF000_0008, 32'hABCD_0155);
    stepCycle();
    issue(0, 1'b0, 32'hF000_0004, 32'h0);
    stepCycle();
    stepCycle();

    sw = 18'h2A5A5; mSw = 18'h2A5A5;
    key = 4'hA; mKey = 4'hA;
    repeat (2) stepCycle();
    issue(0, 1'b0, 32'hF000_0014, 32'h0);
    stepCycle();
    issue(1, 1'b0, 32'hF000_0010, 32'h0);
    stepCycle();
    stepCycle();

    issue(0, 1'b1, 32'hF000_000C, 32'hDEAD_BEEF);
    stepCycle();
    issue(0, 1'b1, 32'hF000_0010, 32'hCAFE_F00D);
    stepCycle();
    stepCycle();

    issue(1, 1'b1, 32'h0000_0100, 32'h0000_DEAD);
    stepCycle();
    stepCycle();

    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!reqV[p] && $urandom_range(0, 3) != 0) genReq(p);
      end
      stepCycle();
    end
    repeat (3) stepCycle();

    // Read granted, then reset asserted in the following cycle.
    issue(0, 1'b0, 32'h0000_0040, 32'h0);
    stepCycle();
    reset = 1'b1;
    issue(0, 1'b0, 32'h0000_0080, 32'h0);
    issue(1, 1'b0, 32'h0000_00C0, 32'h0);
    @(negedge clk);
    checkEq("rst2_cpu_rvalid", cpu_rvalid, 1'b0);
    checkEq("rst2_dbg_rvalid", dbg_rvalid, 1'b0);
    checkEq("rst2_gnt", {cpu_gnt, dbg_gnt}, 2'b00);
    checkEq("rst2_mem_we", mem_we, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkEq("rst2_hex", hex, 32'h0);
    checkEq("rst2_ledr", ledr, 18'h0);
    checkEq("rst2_ledg", ledg, 9'h0);
    checkEq("rst2_rvalid_b", {cpu_rvalid, dbg_rvalid}, 2'b00);
    @(posedge clk);
    #1;
    reset = 1'b0;
    mLast = 1'b1; mHex = '0; mLedr = '0; mLedg = '0; rspVld = 1'b0;
    drive();
    stepCycle();
    repeat (3) stepCycle();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
